gl_fb_writer: RTL and testbench

//  Read end of the raster pixel FIFO; fifo_96 (pixel_fifo) is written by the rasterizer on clk2.

---
 rtl/gl_fb_writer_if.sv | 13 +
 rtl/gl_fb_writer.sv | 151 +++++++++++++++
 tb/tb_gl_fb_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gl_fb_writer_if.sv
// Framebuffer write port: one 32-bit word per request, held stable until acknowledged.
interface gl_fb_writer_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              fb_wr_req;
  logic [ADDR_W-1:0] fb_wr_addr;
  logic [DATA_W-1:0] fb_wr_data;
  logic              fb_wr_ack;

  modport master (output fb_wr_req, output fb_wr_addr, output fb_wr_data, input fb_wr_ack);
  modport slave  (input fb_wr_req, input fb_wr_addr, input fb_wr_data, output fb_wr_ack);
endinterface

// File: rtl/gl_fb_writer.sv
// Drains rasterizer pixel words from the pixel FIFO, clips them to the framebuffer,
// writes each surviving pixel over the req/ack port and reports end-of-frame markers.
module gl_fb_writer #(
  parameter logic [31:0] FB_BASE   = 32'h0000_0000,
  parameter int unsigned FB_WIDTH  = 640,
  parameter int unsigned FB_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [95:0]           pixel_fifo_dout,
  input  logic                  pixel_fifo_empty,
  output logic                  pixel_fifo_rd_en,
  gl_fb_writer_if.master        fb,
  output logic                  frame_done,
  output logic [31:0]           frame_pixel_count,
  output logic [15:0]           clip_count,
  output logic                  busy
);
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned PIX_W   = 96;
  localparam int unsigned COORD_W = 16;
  localparam int unsigned CLIP_W  = 16;
  localparam logic [WORD_W-1:0] WIDTH_W  = WORD_W'(FB_WIDTH);
  localparam logic [WORD_W-1:0] HEIGHT_W = WORD_W'(FB_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_CALC, S_WRITE, S_EOF
  } state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [WORD_W-1:0]   col_q, col_d;
  logic                req_q, req_d;
  logic [WORD_W-1:0]   addr_q, addr_d, data_q, data_d;
  logic                frame_done_q, frame_done_d;
  logic [WORD_W-1:0]   fpc_q, fpc_d, pix_cnt_q, pix_cnt_d;
  logic [CLIP_W-1:0]   clip_q, clip_d;
  logic                busy_q, busy_d;
  logic                rd_en_c;

  logic [WORD_W-1:0]   in_x, in_y, in_col, pix_idx;
  logic                in_clip, is_marker;

  // Unpack the FIFO word and classify it while it is presented in LATCH
  assign {in_x, in_y, in_col} = pixel_fifo_dout;
  assign is_marker = (pixel_fifo_dout == {PIX_W{1'b1}});
  assign in_clip   = (|in_x[WORD_W-1:COORD_W]) || (|in_y[WORD_W-1:COORD_W]) ||
                     (in_x >= WIDTH_W) || (in_y >= HEIGHT_W);
  assign pix_idx   = WORD_W'(y_q) * WIDTH_W + WORD_W'(x_q);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    col_d        = col_q;
    req_d        = req_q;
    addr_d       = addr_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    fpc_d        = fpc_q;
    clip_d       = clip_q;
    pix_cnt_d    = pix_cnt_q;
    rd_en_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && !pixel_fifo_empty) begin
          rd_en_c = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        x_d   = in_x[COORD_W-1:0];
        y_d   = in_y[COORD_W-1:0];
        col_d = in_col;
        if (is_marker) begin
          state_d = S_EOF;
        end else if (in_clip) begin
          if (clip_q != {CLIP_W{1'b1}}) clip_d = clip_q + CLIP_W'(1);
          state_d = S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        addr_d  = FB_BASE + (pix_idx << 2);
        data_d  = col_q;
        req_d   = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Request, address and data stay frozen until the slave accepts
        if (req_q && fb.fb_wr_ack) begin
          req_d     = 1'b0;
          pix_cnt_d = pix_cnt_q + WORD_W'(1);
          state_d   = S_IDLE;
        end
      end
      S_EOF: begin
        frame_done_d = 1'b1;
        fpc_d        = pix_cnt_q;
        pix_cnt_d    = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      fpc_q        <= '0;
      clip_q       <= '0;
      pix_cnt_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_q        <= col_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      fpc_q        <= fpc_d;
      clip_q       <= clip_d;
      pix_cnt_q    <= pix_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign pixel_fifo_rd_en  = rd_en_c;
  assign fb.fb_wr_req      = req_q;
  assign fb.fb_wr_addr     = addr_q;
  assign fb.fb_wr_data     = data_q;
  assign frame_done        = frame_done_q;
  assign frame_pixel_count = fpc_q;
  assign clip_count        = clip_q;
  assign busy              = busy_q;
endmodule

// File: tb/tb_gl_fb_writer.sv
// Self-checking bench for gl_fb_writer: FIFO and memory-port models plus a
// pixel-level reference of expected writes, clip count and frame counts.
module tb_gl_fb_writer;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int unsigned W      = 640;
  localparam int unsigned H      = 480;
  localparam logic [95:0] MARKER = {96{1'b1}};

  logic        clk = 1'b0;
  logic        reset, enable, rd_en, empty, frame_done, busy;
  logic [95:0] dout;
  logic [31:0] fpc;
  logic [15:0] clip;

  gl_fb_writer_if fbi ();

  gl_fb_writer #(.FB_BASE(BASE), .FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_fifo_dout(dout), .pixel_fifo_empty(empty), .pixel_fifo_rd_en(rd_en),
    .fb(fbi.master), .frame_done(frame_done), .frame_pixel_count(fpc),
    .clip_count(clip), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO storage: main pushes, monitor pops
  logic [95:0] mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign empty = (push_cnt == pop_cnt);

  // Memory-port responder settings (written by main)
  int ack_delay = 0;
  bit spurious  = 1'b0;

  // Monitor records
  int cyc, rd_cnt, last_rd_cyc, rd_gap, lat_last, wr_cnt, hold_run, hold_last, fd_cnt;
  int viol_rd_empty, viol_rd_busy, viol_stable, viol_fd_long;
  logic [31:0] wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  logic [31:0] fd_val  [0:63];

  initial begin : monitor
    logic p_req, p_ack, p_fd, take;
    logic [31:0] p_addr, p_data;
    cyc = 0; rd_cnt = 0; last_rd_cyc = 0; rd_gap = 0; lat_last = 0; wr_cnt = 0;
    hold_run = 0; hold_last = 0; fd_cnt = 0;
    viol_rd_empty = 0; viol_rd_busy = 0; viol_stable = 0; viol_fd_long = 0;
    p_req = 1'b0; p_ack = 1'b0; p_fd = 1'b0; p_addr = '0; p_data = '0;
    dout = '0;
    forever begin
      @(negedge clk);
      cyc++;
      take = (rd_en === 1'b1);
      if (take) begin
        rd_cnt++;
        rd_gap = cyc - last_rd_cyc;
        last_rd_cyc = cyc;
        if (empty) viol_rd_empty++;
        if (busy === 1'b1) viol_rd_busy++;
      end
      if (fbi.fb_wr_req === 1'b1) begin
        if (!p_req) lat_last = cyc - last_rd_cyc - 1;
        if (p_req && !p_ack && (fbi.fb_wr_addr !== p_addr || fbi.fb_wr_data !== p_data))
          viol_stable++;
        hold_run++;
        if (fbi.fb_wr_ack === 1'b1) begin
          wr_addr[8'(wr_cnt)] = fbi.fb_wr_addr;
          wr_data[8'(wr_cnt)] = fbi.fb_wr_data;
          wr_cnt++;
          hold_last = hold_run;
          hold_run  = 0;
        end
      end else begin
        hold_run = 0;
      end
      if (frame_done === 1'b1) begin
        fd_val[6'(fd_cnt)] = fpc;
        fd_cnt++;
        if (p_fd) viol_fd_long++;
      end
      p_req  = (fbi.fb_wr_req === 1'b1);
      p_ack  = (fbi.fb_wr_ack === 1'b1);
      p_fd   = (frame_done === 1'b1);
      p_addr = fbi.fb_wr_addr;
      p_data = fbi.fb_wr_data;
      @(posedge clk);
      #1;
      if (take) begin
        dout = mem[8'(pop_cnt)];
        pop_cnt++;
      end
    end
  end

  initial begin : responder
    int hold;
    hold = 0;
    fbi.fb_wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (fbi.fb_wr_req === 1'b1) begin
        fbi.fb_wr_ack = (hold == ack_delay);
        hold++;
      end else begin
        fbi.fb_wr_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        hold = 0;
      end
    end
  end

  // Reference model state
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  logic [31:0] exp_fd_q   [$];
  int          model_cnt = 0;
  logic [15:0] exp_clip  = '0;
  int          wr_seen = 0;
  int          fd_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [95:0] w);
    mem[8'(push_cnt)] = w;
    push_cnt++;
  endtask

  task automatic push_pix(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    push_word({x, y, c});
    if (x >= 32'(W) || y >= 32'(H)) begin
      if (exp_clip != 16'hFFFF) exp_clip++;
    end else begin
      exp_addr_q.push_back(BASE + (y * 32'(W) + x) * 32'd4);
      exp_data_q.push_back(c);
      model_cnt++;
    end
  endtask

  task automatic push_marker();
    push_word(MARKER);
    exp_fd_q.push_back(32'(model_cnt));
    model_cnt = 0;
  endtask

  task automatic push_rand(input int clip_pct);
    logic [31:0] x, y, c;
    x = $urandom_range(0, W - 1);
    y = $urandom_range(0, H - 1);
    c = {8'h00, 24'($urandom)};
    if ($urandom_range(0, 99) < 32'(clip_pct)) begin
      case ($urandom_range(0, 3))
        0: x = 32'(W) + $urandom_range(0, 1000);
        1: y = 32'(H) + $urandom_range(0, 1000);
        2: x = {16'($urandom_range(1, 16'hFFFF)), x[15:0]};
        default: y = {16'($urandom_range(1, 16'hFFFF)), y[15:0]};
      endcase
    end
    push_pix(x, y, c);
  endtask

  task automatic check_new();
    while (wr_seen < wr_cnt) begin
      if (exp_addr_q.size() == 0) begin
        chk("extra_write", wr_addr[8'(wr_seen)], 32'hDEAD_BEEF);
      end else begin
        chk("wr_addr", wr_addr[8'(wr_seen)], exp_addr_q.pop_front());
        chk("wr_data", wr_data[8'(wr_seen)], exp_data_q.pop_front());
      end
      wr_seen++;
    end
    while (fd_seen < fd_cnt) begin
      if (exp_fd_q.size() == 0) chk("extra_frame_done", fd_val[6'(fd_seen)], 32'hDEAD_BEEF);
      else chk("frame_pixel_count", fd_val[6'(fd_seen)], exp_fd_q.pop_front());
      fd_seen++;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(pop_cnt == push_cnt && busy === 1'b0 && fbi.fb_wr_req === 1'b0) && n < budget) begin
      tick(1);
      n++;
    end
    tick(2);
    chk(tag, 32'(n < budget), 32'd1);
    check_new();
    chk({tag, "_missing_writes"}, 32'(exp_addr_q.size()), 32'd0);
    chk({tag, "_missing_frames"}, 32'(exp_fd_q.size()), 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (fbi.fb_wr_req !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(n < 60), 32'd1);
  endtask

  initial begin : main
    int rd0, wr0;
    reset  = 1'b0;
    enable = 1'b0;
    tick(3);
    chk("rst_req",   32'(fbi.fb_wr_req), 32'd0);
    chk("rst_addr",  fbi.fb_wr_addr, 32'd0);
    chk("rst_data",  fbi.fb_wr_data, 32'd0);
    chk("rst_fd",    32'(frame_done), 32'd0);
    chk("rst_fpc",   fpc, 32'd0);
    chk("rst_clip",  32'(clip), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);

    reset  = 1'b1;
    enable = 1'b1;

    // Single pixel, immediate ack
    push_pix(32'd5, 32'd2, 32'h00FF_8000);
    drain("single_drain", 100);
    chk("single_addr", wr_addr[0], 32'h0000_2414);
    chk("single_data", wr_data[0], 32'h00FF_8000);
    chk("lat_rd_to_req", 32'(lat_last), 32'd3);
    chk("hold_immediate", 32'(hold_last), 32'd1);

    // Back-to-back pixels: one dequeue every 5 cycles
    push_rand(0);
    push_rand(0);
    drain("b2b_drain", 100);
    chk("rd_period", 32'(rd_gap), 32'd5);

    // Clipping boundaries
    wr0 = wr_cnt;
    push_pix(32'd640, 32'd0, 32'h0011_2233);
    push_pix(32'd0, 32'd480, 32'h0044_5566);
    push_pix(32'h0001_0000, 32'd0, 32'h0077_8899);
    drain("clip_drain", 100);
    chk("clip_three", 32'(clip), 32'd3);
    chk("clip_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Slow ack: 10 cycles low, then accepted
    ack_delay = 10;
    rd0 = rd_cnt;
    push_rand(0);
    push_rand(0);
    drain("slow_drain", 300);
    chk("slow_hold", 32'(hold_last), 32'd11);
    chk("slow_stable", 32'(viol_stable), 32'd0);
    chk("slow_rd_cnt", 32'(rd_cnt - rd0), 32'd2);

    // Close the running frame, then a 3-pixel frame and an empty one
    ack_delay = 0;
    push_marker();
    drain("flush_frame", 100);
    ack_delay = $urandom_range(0, 3);
    repeat (3) push_rand(0);
    push_marker();
    push_marker();
    drain("frame3_drain", 300);

    // Randomised batch with spurious acks while idle
    spurious  = 1'b1;
    ack_delay = $urandom_range(0, 2);
    repeat (24) push_rand(25);
    push_marker();
    drain("rand_drain", 2000);
    chk("rand_clip", 32'(clip), 32'(exp_clip));
    spurious  = 1'b0;

    // enable low: FIFO not empty but no dequeue
    enable    = 1'b0;
    ack_delay = 3;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    push_rand(0);
    push_rand(0);
    tick(10);
    chk("en0_no_rd", 32'(rd_cnt - rd0), 32'd0);
    chk("en0_idle", 32'(busy), 32'd0);
    // Drop enable during WRITE: that pixel finishes, nothing further
    enable = 1'b1;
    wait_req("en_req_seen");
    enable = 1'b0;
    tick(15);
    chk("en_drop_rd", 32'(rd_cnt - rd0), 32'd1);
    chk("en_drop_wr", 32'(wr_cnt - wr0), 32'd1);
    chk("en_drop_idle", 32'(busy), 32'd0);
    check_new();
    enable = 1'b1;
    drain("en_resume", 200);

    // Reset with a write pending
    ack_delay = 0;
    push_marker();
    drain("pre_rst_frame", 100);
    push_rand(0);
    drain("pre_rst_pix", 100);
    ack_delay = 1000;
    push_rand(0);
    wait_req("rst_req_seen");
    tick(2);
    chk("rst_req_pending", 32'(fbi.fb_wr_req), 32'd1);
    reset = 1'b0;
    tick(1);
    chk("rst2_req",  32'(fbi.fb_wr_req), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_clip", 32'(clip), 32'd0);
    chk("rst2_fpc",  fpc, 32'd0);
    chk("rst2_addr", fbi.fb_wr_addr, 32'd0);
    reset = 1'b1;
    void'(exp_addr_q.pop_back());
    void'(exp_data_q.pop_back());
    model_cnt = 0;
    exp_clip  = '0;
    ack_delay = 0;
    tick(3);
    chk("rst2_req_low", 32'(fbi.fb_wr_req), 32'd0);
    push_marker();
    drain("post_rst_frame", 100);

    chk("never_rd_when_empty", 32'(viol_rd_empty), 32'd0);
    chk("never_rd_when_busy",  32'(viol_rd_busy), 32'd0);
    chk("fd_single_cycle",     32'(viol_fd_long), 32'd0);
    chk("req_stable_all",      32'(viol_stable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
